// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller in front of a simple dual-port RAM with a 1-cycle registered read.
// Latency: a pushed word is poppable next cycle; popped data and pop_valid appear 1 cycle after the pop.
// Backpressure: push is dropped while full and pop is ignored while empty. The optional sticky
// overflow/underflow flags are compiled in with FIFO_ERR_EN.
module fifo_ctrl #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic [AWIDTH:0]   count,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    output logic              ram_re,
    output logic [AWIDTH-1:0] ram_raddr,
    input  logic [DWIDTH-1:0] ram_rdata
`ifdef FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    // Occupancy value that means "every RAM slot holds a live entry".
    localparam logic [AWIDTH:0]   DEPTH   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              pop_valid_q, pop_valid_d;
    logic              wr_ok, rd_ok;

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
`endif

    // Status flags come only from registered occupancy, so there is no path from push/pop to them.
    always_comb begin
        full  = (count_q == DEPTH);
        empty = (count_q == '0);
        count = count_q;
    end

    // Accept decode and RAM strobes. Strobes are held low while in reset so no stray RAM access occurs.
    always_comb begin
        wr_ok     = push & ~full;
        rd_ok     = pop & ~empty;
        ram_we    = wr_ok & ~rst;
        ram_waddr = wptr_q;
        ram_wdata = push_data;
        ram_re    = rd_ok & ~rst;
        ram_raddr = rptr_q;
        pop_data  = ram_rdata;
        pop_valid = pop_valid_q;
    end

    // Next-state: pointers wrap naturally at AWIDTH bits. Occupancy moves only when exactly one side is accepted.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_valid_d = rd_ok;
        if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef FIFO_ERR_EN
    // Sticky error flags: any illegal request latches until reset.
    always_comb begin
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: a RAM model plus a queue-based reference model that is checked every cycle.
// Latency: the model predicts pop data one cycle after each accepted pop.
// Backpressure: stimulus deliberately pushes while full and pops while empty.
module tb_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          full;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
`ifdef FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .empty     (empty),
        .count     (count),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef FIFO_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple dual-port RAM with a registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of stored words, plus running totals of accepted writes and reads.
    logic [DW-1:0] mq[$];
    int            wtot, rtot;
    bit            exp_pv;
    logic [DW-1:0] exp_pd;
    bit            ovf, unf;

    // Compare process: inputs are stable at the falling edge, so this edge is used to check the
    // DUT outputs and then advance the model by one clock.
    always @(negedge clk) begin
        int sz;
        bit wok, rok;
        if (rst) begin
            mq.delete();
            wtot = 0; rtot = 0; exp_pv = 0; ovf = 0; unf = 0;
            chk("rst_count", 32'(count), 0);
            chk("rst_empty", 32'(empty), 1);
            chk("rst_full", 32'(full), 0);
            chk("rst_pop_valid", 32'(pop_valid), 0);
            chk("rst_ram_we", 32'(ram_we), 0);
            chk("rst_ram_re", 32'(ram_re), 0);
        end else begin
            sz  = mq.size();
            wok = push && (sz < DEPTH);
            rok = pop && (sz > 0);
            chk("count", 32'(count), 32'(sz));
            chk("empty", 32'(empty), 32'(sz == 0));
            chk("full", 32'(full), 32'(sz == DEPTH));
            chk("ram_we", 32'(ram_we), 32'(wok));
            chk("ram_re", 32'(ram_re), 32'(rok));
            if (wok) begin
                chk("ram_waddr", 32'(ram_waddr), 32'(wtot % DEPTH));
                chk("ram_wdata", 32'(ram_wdata), 32'(push_data));
            end
            if (rok) chk("ram_raddr", 32'(ram_raddr), 32'(rtot % DEPTH));
            chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
            if (exp_pv) chk("pop_data", 32'(pop_data), 32'(exp_pd));
`ifdef FIFO_ERR_EN
            chk("overflow", 32'(overflow), 32'(ovf));
            chk("underflow", 32'(underflow), 32'(unf));
            if (push && sz == DEPTH) ovf = 1;
            if (pop && sz == 0) unf = 1;
`endif
            exp_pv = rok;
            if (rok) begin
                exp_pd = mq.pop_front();
                rtot++;
            end
            if (wok) begin
                mq.push_back(push_data);
                wtot++;
            end
        end
    end

    // Drive one clock of inputs. The task starts and ends 1 ns after a rising edge.
    task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
        push = p; pop = q; push_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pp, qp;
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("init_count", 32'(count), 0);
        chk("init_empty", 32'(empty), 1);
        chk("init_full", 32'(full), 0);
        chk("init_pop_valid", 32'(pop_valid), 0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i));
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);

        // Push while full is dropped.
        push = 1; pop = 0; push_data = 8'hEE;
        #1 chk("full_push_we", 32'(ram_we), 0);
        @(posedge clk); #1;
        chk("full_push_count", 32'(count), 16);
`ifdef FIFO_ERR_EN
        chk("overflow_set", 32'(overflow), 1);
`endif

        // Drain: each word appears one cycle after its pop.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00);
            chk("drain_pv", 32'(pop_valid), 1);
            chk("drain_data", 32'(pop_data), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);

        // Pop while empty is ignored.
        push = 0; pop = 1;
        #1 chk("empty_pop_re", 32'(ram_re), 0);
        @(posedge clk); #1;
        chk("empty_pop_pv", 32'(pop_valid), 0);
`ifdef FIFO_ERR_EN
        chk("underflow_set", 32'(underflow), 1);
`endif

        // Push and pop together while empty: only the push is accepted.
        step(1, 1, 8'h55);
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_pv", 32'(pop_valid), 0);
        step(0, 1, 8'h00);
        chk("pp_empty_data", 32'(pop_data), 32'h55);

        // Wrap: offset the pointers by 10, then cross 15 -> 0.
        for (int i = 0; i < 10; i++) step(1, 0, 8'(i));
        for (int i = 0; i < 10; i++) step(0, 1, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'hA0 + i));
        chk("wrap_full", 32'(full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00);
            chk("wrap_data", 32'(pop_data), 32'(8'hA0 + i));
        end

        // Simultaneous push and pop at occupancy 5.
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 8'(8'h40 + i));
            chk("simul_count", 32'(count), 5);
            chk("simul_data", 32'(pop_data), (i < 5) ? 32'(8'h30 + i) : 32'(8'h40 + i - 5));
        end
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
        chk("simul_empty", 32'(empty), 1);

        // Random traffic with changing push/pop biases, so both full and empty are visited.
        for (int ph = 0; ph < 6; ph++) begin
            pp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            qp = 100 - pp;
            for (int i = 0; i < 250; i++)
                step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < qp, 8'($urandom));
        end

        // Asynchronous reset in the middle of a cycle with traffic pending.
        step(0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i));
        #2;
        rst = 1; push = 1; pop = 1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_pop_valid", 32'(pop_valid), 0);
        chk("arst_ram_we", 32'(ram_we), 0);
        chk("arst_ram_re", 32'(ram_re), 0);
`ifdef FIFO_ERR_EN
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_underflow", 32'(underflow), 0);
`endif
        @(posedge clk); #1;
        rst = 0; push = 0; pop = 0;
        step(1, 0, 8'h77);
        step(0, 1, 8'h00);
        chk("post_rst_data", 32'(pop_data), 32'h77);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
